shader_load_scheduler: RTL and testbench

Sequences host program uploads into the circular shader instruction memory. Buffers instruction bytes from the SPI receiver, tracks the memory's rotation caused by shader execution, and issues shift/load strobes only while the memory is idle (vertical blanking, no execution). This lets a new shader be written at any time without corrupting the instruction stream of a frame being drawn. Sits between `spi_receiver` and `shader_memory`; the top level ORs its `mem_shift_o` with the execute-shift.

---
 rtl/shader_pkg.sv | 15 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/shader_load_scheduler.sv | 102 ++++++++++
 tb/tb_shader_load_scheduler.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shader_pkg.sv
// Shared types for the shader upload path: instruction word, scheduler
// state encoding and the default shader memory depth.
package shader_pkg;

  localparam int NUM_INSTR_DEF = 8;

  typedef logic [7:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_LOAD  = 2'd2
  } load_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a flush and a push in the same cycle leave
// exactly the pushed word in the FIFO.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Flush first so a same-cycle push lands in the emptied FIFO.
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    if (do_push) begin
      mem_d[wr_ptr_d] = wdata_i;
      wr_ptr_d        = wr_ptr_d + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_d + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/shader_load_scheduler.sv
// Buffers uploaded instruction bytes and writes them into the rotating shader
// memory only during idle windows (vblank with no execution shift).
module shader_load_scheduler
  import shader_pkg::*;
#(
  parameter int NUM_INSTR  = NUM_INSTR_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       prog_start_i,
  input  logic       wr_valid_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  input  logic       vblank_i,
  input  logic       exec_shift_i,
  output logic       mem_shift_o,
  output logic       mem_load_o,
  output logic [7:0] mem_instr_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int RW = $clog2(NUM_INSTR);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  load_state_t   state_q, state_d;
  logic [RW-1:0] rot_q, rot_d;
  logic [RW-1:0] wptr_q, wptr_d;
  logic          window, load_active;
  logic          fifo_full, fifo_empty, fifo_push;
  logic [LW-1:0] fifo_level;
  instr_t        fifo_head;

  // Strobes are gated by the live window so they drop in the same cycle
  // vblank ends or execution shifts, whatever the registered state says.
  assign window      = vblank_i & ~exec_shift_i;
  assign load_active = window & (state_q == ST_LOAD) & ~fifo_empty;
  assign mem_load_o  = load_active;
  assign mem_shift_o = load_active | (window & (state_q == ST_ALIGN));
  assign mem_instr_o = load_active ? fifo_head : '0;
  assign done_o      = load_active & (wptr_q == RW'(NUM_INSTR - 1));
  assign busy_o      = ~fifo_empty;
  assign wr_ready_o  = ~fifo_full;
  assign fifo_push   = wr_valid_i & ~fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (prog_start_i),
    .push_i  (fifo_push),
    .pop_i   (load_active),
    .wdata_i (wr_data_i),
    .rdata_o (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rot_d   = rot_q + RW'(exec_shift_i | mem_shift_o);
    wptr_d  = prog_start_i ? '0 : wptr_q + RW'(load_active);
    state_d = state_q;
    // A restart re-targets slot 0, so any alignment in progress is stale.
    if (!window || prog_start_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_d = (rot_q == wptr_q) ? ST_LOAD : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (rot_q + RW'(1) == wptr_q) begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_d = (fifo_level > LW'(1)) ? ST_LOAD : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rot_q   <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      wptr_q  <= wptr_d;
    end
  end

endmodule

// File: tb/tb_shader_load_scheduler.sv
// Bench for shader_load_scheduler: directed upload scenarios plus random
// uploads, checked against a queue/rotation model of the shader memory.
module tb_shader_load_scheduler;

  localparam int N  = 8;
  localparam int FD = 4;

  logic       clk;
  logic       rst_ni;
  logic       prog_start;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       vblank;
  logic       exec_shift;
  logic       mem_shift;
  logic       mem_load;
  logic [7:0] mem_instr;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  // Reference model: bytes waiting, absolute memory rotation, next target
  // slot, and the memory contents as written by the load strobes.
  logic [7:0] exp_q[$];
  int         rot_m;
  int         wslot;
  logic [7:0] mem_m [N];
  bit         mon_rdy;

  shader_load_scheduler #(
    .NUM_INSTR  (N),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .prog_start_i (prog_start),
    .wr_valid_i   (wr_valid),
    .wr_data_i    (wr_data),
    .wr_ready_o   (wr_ready),
    .vblank_i     (vblank),
    .exec_shift_i (exec_shift),
    .mem_shift_o  (mem_shift),
    .mem_load_o   (mem_load),
    .mem_instr_o  (mem_instr),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: inputs change at negedge, everything is sampled 3ns later.
  always @(negedge clk) begin
    #3;
    if (!rst_ni) begin
      exp_q.delete();
      rot_m = 0;
      wslot = 0;
    end else begin
      mon_rdy = (exp_q.size() < FD);
      vectors++;
      if (wr_ready !== mon_rdy) begin
        miscompares++;
        $display("FAIL mon_ready: got %b expected %b", wr_ready, mon_rdy);
      end
      vectors++;
      if (busy !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL mon_busy: got %b expected %b", busy, exp_q.size() != 0);
      end
      vectors++;
      if (mem_shift === 1'b1 && !(vblank && !exec_shift)) begin
        miscompares++;
        $display("FAIL mon_window: got shift=1 expected 0 (vblank=%b exec=%b)", vblank, exec_shift);
      end
      vectors++;
      if (mem_load === 1'b1 && mem_shift !== 1'b1) begin
        miscompares++;
        $display("FAIL mon_load_shift: got shift=%b expected 1", mem_shift);
      end
      if (mem_load === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL mon_load_empty: got load=1 expected 0");
        end else begin
          vectors++;
          if (mem_instr !== exp_q[0]) begin
            miscompares++;
            $display("FAIL mon_instr: got %h expected %h", mem_instr, exp_q[0]);
          end
          vectors++;
          if (rot_m != wslot) begin
            miscompares++;
            $display("FAIL mon_slot: got head slot %0d expected %0d", rot_m, wslot);
          end
          vectors++;
          if (done !== (wslot == N - 1)) begin
            miscompares++;
            $display("FAIL mon_done: got %b expected %b", done, wslot == N - 1);
          end
          mem_m[rot_m] = mem_instr;
          void'(exp_q.pop_front());
          wslot = (wslot + 1) % N;
        end
      end else begin
        vectors++;
        if (done !== 1'b0 || mem_instr !== 8'h00) begin
          miscompares++;
          $display("FAIL mon_idle_out: got done=%b instr=%h expected 0/00", done, mem_instr);
        end
      end
      if (prog_start) begin
        exp_q.delete();
        wslot = 0;
      end
      if (wr_valid && mon_rdy) exp_q.push_back(wr_data);
      if (mem_shift === 1'b1 || exec_shift) rot_m = (rot_m + 1) % N;
    end
  end

  task automatic test_reset;
    prog_start = 0; wr_valid = 0; vblank = 0; exec_shift = 0;
    #3;
    vectors++;
    if ({mem_shift, mem_load, busy, done, wr_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00001", {mem_shift, mem_load, busy, done, wr_ready});
    end
    vectors++;
    if (mem_instr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_instr: got %h expected 00", mem_instr);
    end
    @(negedge clk);
  endtask

  task automatic test_full_program;
    int first_ld, last_ld, done_cyc, nld;
    logic [7:0] got[$];
    logic [7:0] want;
    first_ld = -1; last_ld = -1; done_cyc = -1; nld = 0;
    for (int c = 0; c < 16; c++) begin
      vblank = 1; exec_shift = 0;
      prog_start = (c == 0);
      wr_valid = (c >= 1 && c <= 8);
      wr_data = 8'h10 + 8'(c);
      #3;
      if (mem_load === 1'b1) begin
        if (first_ld < 0) first_ld = c;
        last_ld = c;
        nld++;
        got.push_back(mem_instr);
      end
      if (done === 1'b1) done_cyc = c;
      @(negedge clk);
    end
    wr_valid = 0; prog_start = 0;
    vectors++;
    if (nld != 8) begin
      miscompares++;
      $display("FAIL full_count: got %0d loads expected 8", nld);
    end
    vectors++;
    if (last_ld - first_ld != 7) begin
      miscompares++;
      $display("FAIL full_consecutive: got span %0d expected 7", last_ld - first_ld);
    end
    vectors++;
    if (done_cyc != last_ld || done_cyc < 0) begin
      miscompares++;
      $display("FAIL full_done: got cycle %0d expected %0d", done_cyc, last_ld);
    end
    for (int i = 0; i < 8; i++) begin
      want = 8'h11 + 8'(i);
      vectors++;
      if (i >= got.size() || got[i] !== want) begin
        miscompares++;
        $display("FAIL full_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, want);
      end
    end
    #3;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_busy_end: got %b expected 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_align;
    int shifts;
    bit seen;
    logic [7:0] d;
    shifts = 0; seen = 0; d = 8'h00;
    for (int c = 0; c < 3; c++) begin
      vblank = 0; exec_shift = 1; wr_valid = 0; prog_start = 0;
      #3;
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      vblank = 1; exec_shift = 0;
      wr_valid = (c == 0); wr_data = 8'hA5;
      #3;
      if (mem_load === 1'b1 && !seen) begin
        seen = 1;
        d = mem_instr;
      end else if (!seen && mem_shift === 1'b1) begin
        shifts++;
      end
      @(negedge clk);
    end
    wr_valid = 0;
    vectors++;
    if (shifts != 5) begin
      miscompares++;
      $display("FAIL align_shifts: got %0d expected 5", shifts);
    end
    vectors++;
    if (!seen || d !== 8'hA5) begin
      miscompares++;
      $display("FAIL align_load: got seen=%0d data=%h expected 1/a5", seen, d);
    end
    vectors++;
    if (mem_m[0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL align_slot0: got %h expected a5", mem_m[0]);
    end
  endtask

  task automatic test_backpressure;
    int idx, shifts, nld, exp_sh;
    logic [7:0] b [5];
    idx = 0; shifts = 0; nld = 0;
    for (int i = 0; i < 5; i++) b[i] = 8'hC1 + 8'(i);
    for (int c = 0; c < 7; c++) begin
      vblank = 0; exec_shift = 0;
      prog_start = (c == 0);
      wr_valid = 1; wr_data = b[idx];
      #3;
      vectors++;
      if (wr_ready !== (idx < 4)) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: got %b expected %b", c, wr_ready, idx < 4);
      end
      vectors++;
      if (mem_shift !== 1'b0 || mem_load !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_no_strobe[%0d]: got %b%b expected 00", c, mem_shift, mem_load);
      end
      if (wr_ready) idx++;
      @(negedge clk);
    end
    prog_start = 0;
    vectors++;
    if (idx != 4) begin
      miscompares++;
      $display("FAIL bp_accepted: got %0d expected 4", idx);
    end
    exp_sh = (N - rot_m) % N;
    for (int c = 0; c < 40; c++) begin
      vblank = 1; exec_shift = 0;
      wr_valid = (idx < 5); wr_data = b[(idx < 5) ? idx : 4];
      #3;
      if (mem_load === 1'b1) nld++;
      else if (mem_shift === 1'b1) shifts++;
      if (wr_valid && wr_ready) idx++;
      @(negedge clk);
    end
    wr_valid = 0;
    vectors++;
    if (shifts != exp_sh) begin
      miscompares++;
      $display("FAIL bp_align: got %0d expected %0d", shifts, exp_sh);
    end
    vectors++;
    if (nld != 5) begin
      miscompares++;
      $display("FAIL bp_loads: got %0d expected 5", nld);
    end
    vectors++;
    if (mem_m[4] !== 8'hC5) begin
      miscompares++;
      $display("FAIL bp_slot4: got %h expected c5", mem_m[4]);
    end
  endtask

  task automatic test_vblank_drop;
    int idx, nld, resumed, phase, drop_cnt;
    bit finished;
    logic [7:0] p [8];
    idx = 0; nld = 0; resumed = 0; phase = 0; drop_cnt = 0; finished = 0;
    for (int i = 0; i < 8; i++) p[i] = 8'h30 + 8'(i);
    for (int c = 0; c < 80 && !finished; c++) begin
      vblank = (phase == 1 || phase == 3); exec_shift = 0;
      prog_start = (c == 0);
      wr_valid = (idx < 8); wr_data = p[(idx < 8) ? idx : 7];
      #3;
      if (phase == 2 && drop_cnt == 0) begin
        vectors++;
        if (mem_shift !== 1'b0 || mem_load !== 1'b0) begin
          miscompares++;
          $display("FAIL drop_same_cycle: got %b%b expected 00", mem_shift, mem_load);
        end
      end
      if (wr_valid && wr_ready) idx++;
      if (mem_load === 1'b1) begin
        nld++;
        if (phase == 3) resumed++;
      end
      case (phase)
        0: if (idx >= 4) phase = 1;
        1: if (nld == 3) phase = 2;
        2: begin
          drop_cnt++;
          if (drop_cnt == 4) phase = 3;
        end
        default: if (nld >= 8 && busy === 1'b0) finished = 1;
      endcase
      @(negedge clk);
    end
    wr_valid = 0; prog_start = 0;
    vectors++;
    if (!finished || nld != 8) begin
      miscompares++;
      $display("FAIL drop_total: got %0d loads expected 8", nld);
    end
    vectors++;
    if (resumed != 5) begin
      miscompares++;
      $display("FAIL drop_resumed: got %0d expected 5", resumed);
    end
    for (int s = 0; s < 8; s++) begin
      vectors++;
      if (mem_m[s] !== p[s]) begin
        miscompares++;
        $display("FAIL drop_mem[%0d]: got %h expected %h", s, mem_m[s], p[s]);
      end
    end
  endtask

  task automatic test_prog_flush;
    int nld;
    logic [7:0] d;
    nld = 0; d = 8'h00;
    for (int c = 0; c < 3; c++) begin
      vblank = 0; exec_shift = 0;
      prog_start = (c != 1);
      wr_valid = 1;
      wr_data = (c == 0) ? 8'h41 : (c == 1) ? 8'h42 : 8'h7E;
      #3;
      @(negedge clk);
    end
    prog_start = 0; wr_valid = 0;
    #3;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_busy: got %b expected 1", busy);
    end
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      vblank = 1; exec_shift = 0;
      #3;
      if (mem_load === 1'b1) begin
        nld++;
        d = mem_instr;
      end
      @(negedge clk);
    end
    vectors++;
    if (nld != 1 || d !== 8'h7E) begin
      miscompares++;
      $display("FAIL flush_load: got %0d loads data %h expected 1 load 7e", nld, d);
    end
    vectors++;
    if (mem_m[0] !== 8'h7E) begin
      miscompares++;
      $display("FAIL flush_slot0: got %h expected 7e", mem_m[0]);
    end
  endtask

  task automatic test_reset_mid_load;
    int idx;
    bit seen;
    idx = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      vblank = 1; exec_shift = 0;
      prog_start = (c == 0);
      wr_valid = (idx < 4); wr_data = 8'h91 + 8'(idx);
      #3;
      if (mem_load === 1'b1) begin
        seen = 1;
      end else begin
        if (wr_valid && wr_ready) idx++;
        @(negedge clk);
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_mid_no_load: got none expected a load within 30 cycles");
    end
    rst_ni = 0;
    #1;
    vectors++;
    if ({mem_shift, mem_load, busy, done, wr_ready} !== 5'b00001 || mem_instr !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid_async: got %b/%h expected 00001/00",
               {mem_shift, mem_load, busy, done, wr_ready}, mem_instr);
    end
    @(negedge clk);
    wr_valid = 0; prog_start = 0;
    #3;
    vectors++;
    if ({mem_shift, mem_load, busy, done, wr_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL rst_mid_held: got %b expected 00001", {mem_shift, mem_load, busy, done, wr_ready});
    end
    @(negedge clk);
    rst_ni = 1;
  endtask

  task automatic test_random;
    int len, idx, guard;
    bit drained;
    logic [7:0] rp [8];
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) rp[i] = 8'($urandom_range(0, 255));
      idx = 0; guard = 0;
      while (idx < len && guard < 400) begin
        prog_start = (guard == 0);
        wr_valid = (guard == 0) || ($urandom_range(0, 1) == 1);
        wr_data = rp[idx];
        vblank = ($urandom_range(0, 9) < 6);
        exec_shift = ($urandom_range(0, 9) < 2);
        #3;
        if (wr_valid && wr_ready) idx++;
        guard++;
        @(negedge clk);
      end
      prog_start = 0; wr_valid = 0; vblank = 1; exec_shift = 0;
      drained = 0;
      for (int c = 0; c < 40 && !drained; c++) begin
        #3;
        if (busy === 1'b0) drained = 1;
        @(negedge clk);
      end
      vectors++;
      if (idx != len || !drained) begin
        miscompares++;
        $display("FAIL rand_progress[%0d]: got pushed %0d drained %0d expected %0d/1", r, idx, drained, len);
      end
      for (int s = 0; s < 8; s++) begin
        if (s < len) begin
          vectors++;
          if (mem_m[s] !== rp[s]) begin
            miscompares++;
            $display("FAIL rand_mem[%0d][%0d]: got %h expected %h", r, s, mem_m[s], rp[s]);
          end
        end
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rot_m = 0; wslot = 0;
    for (int i = 0; i < N; i++) mem_m[i] = 8'h00;
    rst_ni = 0; prog_start = 0; wr_valid = 0; wr_data = 8'h00; vblank = 0; exec_shift = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1;
    test_reset();
    test_full_program();
    test_align();
    test_backpressure();
    test_vblank_drop();
    test_prog_flush();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
